// File: rtl/bop_multi_tracker.sv
// Buffer-overflow protection: tracks contiguous store runs, commits long
// runs to a circular range table and flags suspicious loads against it.
module bop_multi_tracker #(
  parameter int          NUM_TRACK = 2,
  parameter int          DEPTH     = 8,
  parameter int          MIN_RUN   = 16,
  parameter int          TIMEOUT   = 6,
  parameter int          BIG_RUN   = 100,
  parameter logic [31:0] EXCL_MASK = 32'h0000_0104
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         instr_valid_i,
  input  logic                         en_i,
  input  logic [31:0]                  pc_i,
  input  logic                         is_store_i,
  input  logic                         is_load_i,
  input  logic [1:0]                   size_i,
  input  logic [4:0]                   rs1_i,
  input  logic [4:0]                   rd_i,
  input  logic [31:0]                  addr_i,
  input  logic                         clr_i,
  output logic                         hit_o,
  output logic                         alarm_o,
  output logic [1:0]                   alarm_cause_o,
  output logic [$clog2(DEPTH+1)-1:0]   entries_o,
  output logic                         busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {T_IDLE, T_ACTIVE, T_RETIRE} tst_e;

  tst_e        st_q   [NUM_TRACK];
  tst_e        st_d   [NUM_TRACK];
  logic [31:0] beg_q  [NUM_TRACK];
  logic [31:0] beg_d  [NUM_TRACK];
  logic [31:0] nxt_q  [NUM_TRACK];
  logic [31:0] nxt_d  [NUM_TRACK];
  logic [31:0] cnt_q  [NUM_TRACK];
  logic [31:0] cnt_d  [NUM_TRACK];
  logic [3:0]  tmr_q  [NUM_TRACK];
  logic [3:0]  tmr_d  [NUM_TRACK];
  logic        shv_q  [NUM_TRACK];
  logic        shv_d  [NUM_TRACK];
  logic [31:0] sbeg_q [NUM_TRACK];
  logic [31:0] sbeg_d [NUM_TRACK];
  logic [31:0] snxt_q [NUM_TRACK];
  logic [31:0] snxt_d [NUM_TRACK];
  logic [31:0] scnt_q [NUM_TRACK];
  logic [31:0] scnt_d [NUM_TRACK];

  logic        tv_q   [DEPTH];
  logic        tv_d   [DEPTH];
  logic [31:0] ts_q   [DEPTH];
  logic [31:0] ts_d   [DEPTH];
  logic [31:0] tl_q   [DEPTH];
  logic [31:0] tl_d   [DEPTH];
  logic [31:0] tlen_q [DEPTH];
  logic [31:0] tlen_d [DEPTH];
  logic        tbig_q [DEPTH];
  logic        tbig_d [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [EW-1:0] ent_q, ent_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic [4:0]    lrd_q, lrd_d;
  logic          lrdv_q, lrdv_d;
  logic          alarm_q, alarm_d;
  logic [1:0]    cause_q, cause_d;

  logic                 acc, trk, age, ldv, wl, bl;
  logic                 hit, first_big, chain, fbr;
  logic [31:0]          sz;
  logic [NUM_TRACK-1:0] ext_sel, alc_sel, ev_sel, cm_sel;
  logic                 ext_any, alc_any, ev_any, cm_any, best_v;
  logic [3:0]           best_t;
  logic [31:0]          w_beg, w_nxt, w_cnt;
  logic                 busy;

  always_comb begin
    st_d     = st_q;
    beg_d    = beg_q;
    nxt_d    = nxt_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    shv_d    = shv_q;
    sbeg_d   = sbeg_q;
    snxt_d   = snxt_q;
    scnt_d   = scnt_q;
    tv_d     = tv_q;
    ts_d     = ts_q;
    tl_d     = tl_q;
    tlen_d   = tlen_q;
    tbig_d   = tbig_q;
    wr_ptr_d = wr_ptr_q;
    ent_d    = ent_q;
    last_pc_d = last_pc_q;
    lrd_d    = lrd_q;
    lrdv_d   = lrdv_q;
    alarm_d  = alarm_q;
    cause_d  = cause_q;

    acc = instr_valid_i && !clr_i && (pc_i != last_pc_q);
    sz  = 32'd1 << size_i;
    trk = acc && en_i && is_store_i && (size_i != 2'd3)
          && !EXCL_MASK[rs1_i];
    age = acc && en_i;
    ldv = acc && is_load_i && (size_i != 2'd3);
    wl  = ldv && (size_i == 2'd2);
    bl  = ldv && (size_i == 2'd0);

    ext_sel = '0;
    ext_any = 1'b0;
    for (int i = 0; i < NUM_TRACK; i++) begin
      // a retiring tracker's shadow run may keep growing while it drains
      if (trk && !ext_any &&
          ((st_q[i] == T_ACTIVE && nxt_q[i] == addr_i) ||
           (st_q[i] == T_RETIRE && shv_q[i] && snxt_q[i] == addr_i))) begin
        ext_sel[i] = 1'b1;
        ext_any    = 1'b1;
      end
    end

    alc_sel = '0;
    alc_any = 1'b0;
    for (int i = 0; i < NUM_TRACK; i++) begin
      if (trk && !ext_any && !alc_any && st_q[i] == T_IDLE) begin
        alc_sel[i] = 1'b1;
        alc_any    = 1'b1;
      end
    end

    ev_sel = '0;
    best_v = 1'b0;
    best_t = '0;
    for (int i = 0; i < NUM_TRACK; i++) begin
      if (trk && !ext_any && !alc_any && st_q[i] == T_ACTIVE &&
          (!best_v || tmr_q[i] < best_t)) begin
        best_v    = 1'b1;
        best_t    = tmr_q[i];
        ev_sel    = '0;
        ev_sel[i] = 1'b1;
      end
    end
    ev_any = best_v;

    cm_sel = '0;
    cm_any = 1'b0;
    w_beg  = '0;
    w_nxt  = '0;
    w_cnt  = '0;
    for (int i = 0; i < NUM_TRACK; i++) begin
      if (!cm_any && st_q[i] == T_RETIRE) begin
        cm_sel[i] = 1'b1;
        cm_any    = 1'b1;
        w_beg     = beg_q[i];
        w_nxt     = nxt_q[i];
        w_cnt     = cnt_q[i];
      end
    end

    for (int i = 0; i < NUM_TRACK; i++) begin
      if (ext_sel[i]) begin
        if (st_q[i] == T_ACTIVE) begin
          nxt_d[i] = addr_i + sz;
          cnt_d[i] = cnt_q[i] + sz;
          tmr_d[i] = 4'(TIMEOUT);
        end else begin
          snxt_d[i] = addr_i + sz;
          scnt_d[i] = scnt_q[i] + sz;
        end
      end else if (alc_sel[i]) begin
        st_d[i]  = T_ACTIVE;
        beg_d[i] = addr_i;
        nxt_d[i] = addr_i + sz;
        cnt_d[i] = sz;
        tmr_d[i] = 4'(TIMEOUT);
      end else if (ev_any && ev_sel[i]) begin
        st_d[i]   = T_RETIRE;
        shv_d[i]  = 1'b1;
        sbeg_d[i] = addr_i;
        snxt_d[i] = addr_i + sz;
        scnt_d[i] = sz;
      end else if (age && st_q[i] == T_ACTIVE) begin
        if (tmr_q[i] == 4'd0) st_d[i] = T_RETIRE;
        else                  tmr_d[i] = tmr_q[i] - 4'd1;
      end
      if (cm_sel[i]) begin
        if (shv_d[i]) begin
          st_d[i]  = T_ACTIVE;
          beg_d[i] = sbeg_d[i];
          nxt_d[i] = snxt_d[i];
          cnt_d[i] = scnt_d[i];
          tmr_d[i] = 4'(TIMEOUT);
          shv_d[i] = 1'b0;
        end else begin
          st_d[i] = T_IDLE;
        end
      end
    end

    if (cm_any && w_cnt > 32'(MIN_RUN)) begin
      tv_d[wr_ptr_q]   = 1'b1;
      ts_d[wr_ptr_q]   = w_beg;
      tl_d[wr_ptr_q]   = w_nxt - 32'd1;
      tlen_d[wr_ptr_q] = w_cnt;
      tbig_d[wr_ptr_q] = w_cnt > 32'(BIG_RUN);
      wr_ptr_d         = wr_ptr_q + 1'b1;
      if (ent_q != EW'(DEPTH)) ent_d = ent_q + 1'b1;
    end

    hit       = 1'b0;
    first_big = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (tv_q[e] && ts_q[e] <= addr_i && addr_i <= tl_q[e]) hit = 1'b1;
      if (tv_q[e] && addr_i == ts_q[e] && tlen_q[e] > 32'd8)
        first_big = 1'b1;
    end

    chain = wl && hit && lrdv_q && (rs1_i == lrd_q);
    fbr   = bl && first_big;
    if (wl) begin
      lrdv_d = hit;
      if (hit) lrd_d = rd_i;
    end
    if (!alarm_q && (chain || fbr)) begin
      alarm_d = 1'b1;
      cause_d = chain ? 2'd1 : 2'd2;
    end
    if (acc) last_pc_d = pc_i;

    if (clr_i) begin
      for (int i = 0; i < NUM_TRACK; i++) begin
        st_d[i]   = T_IDLE;
        beg_d[i]  = '0;
        nxt_d[i]  = '0;
        cnt_d[i]  = '0;
        tmr_d[i]  = '0;
        shv_d[i]  = 1'b0;
        sbeg_d[i] = '0;
        snxt_d[i] = '0;
        scnt_d[i] = '0;
      end
      for (int e = 0; e < DEPTH; e++) begin
        tv_d[e]   = 1'b0;
        ts_d[e]   = '0;
        tl_d[e]   = '0;
        tlen_d[e] = '0;
        tbig_d[e] = 1'b0;
      end
      wr_ptr_d = '0;
      ent_d    = '0;
      lrd_d    = '0;
      lrdv_d   = 1'b0;
      alarm_d  = 1'b0;
      cause_d  = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_TRACK; i++) begin
        st_q[i]   <= T_IDLE;
        beg_q[i]  <= '0;
        nxt_q[i]  <= '0;
        cnt_q[i]  <= '0;
        tmr_q[i]  <= '0;
        shv_q[i]  <= 1'b0;
        sbeg_q[i] <= '0;
        snxt_q[i] <= '0;
        scnt_q[i] <= '0;
      end
      for (int e = 0; e < DEPTH; e++) begin
        tv_q[e]   <= 1'b0;
        ts_q[e]   <= '0;
        tl_q[e]   <= '0;
        tlen_q[e] <= '0;
        tbig_q[e] <= 1'b0;
      end
      wr_ptr_q  <= '0;
      ent_q     <= '0;
      last_pc_q <= '0;
      lrd_q     <= '0;
      lrdv_q    <= 1'b0;
      alarm_q   <= 1'b0;
      cause_q   <= 2'd0;
    end else begin
      st_q      <= st_d;
      beg_q     <= beg_d;
      nxt_q     <= nxt_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      shv_q     <= shv_d;
      sbeg_q    <= sbeg_d;
      snxt_q    <= snxt_d;
      scnt_q    <= scnt_d;
      tv_q      <= tv_d;
      ts_q      <= ts_d;
      tl_q      <= tl_d;
      tlen_q    <= tlen_d;
      tbig_q    <= tbig_d;
      wr_ptr_q  <= wr_ptr_d;
      ent_q     <= ent_d;
      last_pc_q <= last_pc_d;
      lrd_q     <= lrd_d;
      lrdv_q    <= lrdv_d;
      alarm_q   <= alarm_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_TRACK; i++)
      if (st_q[i] != T_IDLE) busy = 1'b1;
  end

  assign hit_o         = hit;
  assign alarm_o       = alarm_q;
  assign alarm_cause_o = cause_q;
  assign entries_o     = ent_q;
  assign busy_o        = busy;

endmodule

// File: tb/tb_bop_multi_tracker.sv
// Scoreboard bench for bop_multi_tracker: directed store runs, loads
// and clears; expected outputs queued by the driver, checked by a monitor.
module tb_bop_multi_tracker;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic        en_i = 1'b1;
  logic [31:0] pc_i = '0;
  logic        is_store_i = 1'b0;
  logic        is_load_i = 1'b0;
  logic [1:0]  size_i = '0;
  logic [4:0]  rs1_i = '0;
  logic [4:0]  rd_i = '0;
  logic [31:0] addr_i = '0;
  logic        clr_i = 1'b0;
  logic        hit_o;
  logic        alarm_o;
  logic [1:0]  alarm_cause_o;
  logic [3:0]  entries_o;
  logic        busy_o;

  bop_multi_tracker dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_valid_i (instr_valid_i),
    .en_i          (en_i),
    .pc_i          (pc_i),
    .is_store_i    (is_store_i),
    .is_load_i     (is_load_i),
    .size_i        (size_i),
    .rs1_i         (rs1_i),
    .rd_i          (rd_i),
    .addr_i        (addr_i),
    .clr_i         (clr_i),
    .hit_o         (hit_o),
    .alarm_o       (alarm_o),
    .alarm_cause_o (alarm_cause_o),
    .entries_o     (entries_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int S_HIT = 0, S_ALM = 1, S_CAU = 2, S_ENT = 3, S_BSY = 4;

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] pc = 32'h100;
  logic        en_v = 1'b1;

  task automatic expect_v(input string nm, input int sel,
                          input logic [31:0] e);
    chk_t c;
    c.nm  = nm;
    c.sel = sel;
    c.exp = e;
    sb.push_back(c);
  endtask

  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk_i);
      #2;
      while (sb.size() > 0) begin
        c = sb.pop_front();
        case (c.sel)
          S_HIT:   act = {31'd0, hit_o};
          S_ALM:   act = {31'd0, alarm_o};
          S_CAU:   act = {30'd0, alarm_cause_o};
          S_ENT:   act = {28'd0, entries_o};
          default: act = {31'd0, busy_o};
        endcase
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s got=%0h want=%0h", c.nm, act, c.exp);
        end
      end
    end
  end

  task automatic instr(input logic st, input logic ld,
                       input logic [1:0] sz, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic [31:0] addr);
    @(negedge clk_i);
    instr_valid_i = 1'b1;
    clr_i      = 1'b0;
    en_i       = en_v;
    pc_i       = pc;
    pc         = pc + 32'd4;
    is_store_i = st;
    is_load_i  = ld;
    size_i     = sz;
    rs1_i      = rs1;
    rd_i       = rd;
    addr_i     = addr;
  endtask

  task automatic replay();
    @(negedge clk_i);
  endtask

  task automatic idle(input logic [31:0] addr);
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    clr_i      = 1'b0;
    en_i       = en_v;
    is_store_i = 1'b0;
    is_load_i  = 1'b0;
    addr_i     = addr;
  endtask

  task automatic clear();
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    is_store_i = 1'b0;
    is_load_i  = 1'b0;
    clr_i      = 1'b1;
  endtask

  task automatic alu(input int n);
    for (int k = 0; k < n; k++) instr(1'b0, 1'b0, 2'd0, 5'd0, 5'd0, '0);
  endtask

  task automatic run(input logic [31:0] base, input int n,
                     input logic [1:0] sz);
    for (int k = 0; k < n; k++)
      instr(1'b1, 1'b0, sz, 5'd10, 5'd0, base + k * (32'd1 << sz));
  endtask

  task automatic commit_run(input logic [31:0] base, input int n,
                            input logic [1:0] sz);
    run(base, n, sz);
    alu(7);
    idle('0);
    idle('0);
  endtask

  initial begin
    #12 rst_ni = 1'b1;

    idle(32'h1000);
    expect_v("rst_hit", S_HIT, 0);
    expect_v("rst_alarm", S_ALM, 0);
    expect_v("rst_cause", S_CAU, 0);
    expect_v("rst_entries", S_ENT, 0);
    expect_v("rst_busy", S_BSY, 0);

    instr(1'b1, 1'b0, 2'd2, 5'd2, 5'd0, 32'h7000);
    idle('0);
    expect_v("excl_sp_busy", S_BSY, 0);
    en_v = 1'b0;
    instr(1'b1, 1'b0, 2'd2, 5'd10, 5'd0, 32'h7000);
    en_v = 1'b1;
    idle('0);
    expect_v("en_low_busy", S_BSY, 0);

    run(32'h1000, 20, 2'd0);
    alu(7);
    idle('0);
    expect_v("t1_retire_busy", S_BSY, 1);
    expect_v("t1_pre_entries", S_ENT, 0);
    idle(32'h1013);
    expect_v("t1_entries", S_ENT, 1);
    expect_v("t1_busy_done", S_BSY, 0);
    expect_v("t1_hit_last", S_HIT, 1);
    idle(32'h1014);
    expect_v("t1_miss_after", S_HIT, 0);
    idle(32'h0fff);
    expect_v("t1_miss_before", S_HIT, 0);

    clear();
    idle('0);
    expect_v("t2_clr_entries", S_ENT, 0);
    commit_run(32'h1000, 16, 2'd0);
    expect_v("t2_short_entries", S_ENT, 0);
    expect_v("t2_short_busy", S_BSY, 0);

    commit_run(32'h1000, 20, 2'd0);
    expect_v("t3_entries", S_ENT, 1);
    instr(1'b0, 1'b1, 2'd2, 5'd10, 5'd5, 32'h1004);
    expect_v("t3_lw_hit", S_HIT, 1);
    instr(1'b0, 1'b1, 2'd2, 5'd10, 5'd9, 32'h9000);
    instr(1'b0, 1'b1, 2'd2, 5'd5, 5'd6, 32'h1008);
    idle('0);
    expect_v("t3_broken_chain", S_ALM, 0);
    instr(1'b0, 1'b1, 2'd2, 5'd10, 5'd5, 32'h1004);
    instr(1'b0, 1'b1, 2'd2, 5'd5, 5'd6, 32'h1008);
    expect_v("t3_alarm_early", S_ALM, 0);
    idle('0);
    expect_v("t3_alarm", S_ALM, 1);
    expect_v("t3_cause", S_CAU, 1);
    clear();
    expect_v("t3_alarm_sticky", S_ALM, 1);
    idle('0);
    expect_v("t3_clr_alarm", S_ALM, 0);
    expect_v("t3_clr_cause", S_CAU, 0);
    expect_v("t3_clr_entries", S_ENT, 0);

    commit_run(32'h2000, 8, 2'd2);
    expect_v("t4_entries", S_ENT, 1);
    instr(1'b0, 1'b1, 2'd0, 5'd10, 5'd7, 32'h2001);
    expect_v("t4_lb1_hit", S_HIT, 1);
    idle('0);
    expect_v("t4_lb1_noalarm", S_ALM, 0);
    instr(1'b0, 1'b1, 2'd0, 5'd10, 5'd7, 32'h2000);
    idle('0);
    expect_v("t4_alarm", S_ALM, 1);
    expect_v("t4_cause", S_CAU, 2);
    instr(1'b0, 1'b1, 2'd2, 5'd10, 5'd5, 32'h2004);
    instr(1'b0, 1'b1, 2'd2, 5'd5, 5'd6, 32'h2008);
    idle('0);
    expect_v("t4_cause_kept", S_CAU, 2);
    clear();
    idle('0);

    for (int k = 0; k < 5; k++) begin
      instr(1'b1, 1'b0, 2'd2, 5'd10, 5'd0, 32'h3000 + 4 * k);
      instr(1'b1, 1'b0, 2'd2, 5'd11, 5'd0, 32'h4000 + 4 * k);
    end
    instr(1'b1, 1'b0, 2'd1, 5'd12, 5'd0, 32'h5000);
    expect_v("t5_pre_evict", S_ENT, 0);
    instr(1'b1, 1'b0, 2'd1, 5'd12, 5'd0, 32'h5002);
    expect_v("t5_evict_busy", S_BSY, 1);
    expect_v("t5_evict_entries", S_ENT, 0);
    idle(32'h3010);
    expect_v("t5_commit_entries", S_ENT, 1);
    expect_v("t5_hit_3000", S_HIT, 1);
    idle(32'h4010);
    expect_v("t5_no_4000_yet", S_HIT, 0);
    for (int k = 2; k < 10; k++)
      instr(1'b1, 1'b0, 2'd1, 5'd12, 5'd0, 32'h5000 + 2 * k);
    alu(7);
    idle(32'h4010);
    idle(32'h4010);
    expect_v("t5_entries", S_ENT, 3);
    expect_v("t5_hit_4000", S_HIT, 1);
    expect_v("t5_busy", S_BSY, 0);
    idle(32'h5012);
    expect_v("t5_hit_5000", S_HIT, 1);
    idle(32'h5014);
    expect_v("t5_miss_5014", S_HIT, 0);

    clear();
    idle('0);
    run(32'h6000, 5, 2'd2);
    alu(1);
    replay();
    replay();
    alu(5);
    idle('0);
    idle('0);
    expect_v("t6_replay_busy", S_BSY, 1);
    expect_v("t6_replay_entries", S_ENT, 0);
    alu(1);
    idle('0);
    idle('0);
    expect_v("t6_run0_entries", S_ENT, 1);
    for (int r = 1; r < 9; r++) begin
      commit_run(32'h6000 + 32'h100 * r, 5, 2'd2);
      if (r == 7) expect_v("t6_full_entries", S_ENT, 8);
    end
    idle(32'h6000);
    expect_v("t6_sat_entries", S_ENT, 8);
    expect_v("t6_oldest_gone", S_HIT, 0);
    idle(32'h6100);
    expect_v("t6_second_hit", S_HIT, 1);
    idle(32'h6813);
    expect_v("t6_newest_hit", S_HIT, 1);

    idle('0);
    @(negedge clk_i);
    #4;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
